fifo_uart_tx: RTL

- Read-side consumer for the team's 8-bit FIFO.
- Pops one byte at a time using the FIFO's rd_en/buf_empty/buf_out interface.
- Serialises each byte onto a single line as a UART 8N1 frame.
- Sits between the FIFO and the board TX pin. It is the sole reader of its FIFO.

---
 rtl/fifo_uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/fifo_uart_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

  // Idle-high cycles (POP, LATCH) between a stop bit and the next start bit
  localparam int FRAME_GAP = 2;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running baud counter; bit_end marks the last clk of each serial bit.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int W = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises each as a UART 8N1 frame.
//   state | meaning
//   IDLE  | line high, waiting for enable and a non-empty FIFO
//   POP   | one-cycle rd_en strobe
//   LATCH | FIFO read data valid; captured into the shift register
//   START | start bit (low)
//   DATA  | payload bits, LSB first
//   STOP  | stop bit (high); last cycle pulses tx_done
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [7:0]            bytes_sent
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  bit_end;
  logic                  clear;
  logic                  start_ok;

  // Clearing on the deciding cycle makes every state begin at count 0
  assign clear    = (state_d != state_q);
  assign start_ok = enable && !buf_empty;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = POP;
      POP:     state_d = LATCH;
      LATCH:   state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == LAST_IDX)) state_d = STOP;
      STOP:    if (bit_end) state_d = start_ok ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else if (state_q == LATCH) begin
      shift_q   <= buf_out;
      bit_idx_q <= '0;
    end else if ((state_q == DATA) && bit_end) begin
      shift_q   <= shift_q >> 1;
      bit_idx_q <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_sent <= '0;
    end else if ((state_q == STOP) && bit_end) begin
      bytes_sent <= bytes_sent + 8'd1;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    rd_en   = (state_q == POP);
    busy    = (state_q != IDLE);
    tx_done = (state_q == STOP) && bit_end;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

endmodule
